// File: rtl/mod_counter_ctl.sv
// ============================================================================
// Module   : mod_counter_ctl
// Brief    : Up/down modulus counter with wrap, saturate, one-shot and
//            auto-reload modes, a reload register and a registered
//            terminal-count pulse for cascading.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_ctl #(
  parameter int N       = 8,
  parameter int MAX_VAL = 2**N - 1
) (
  input  logic         sysclk,
  input  logic         reset_n,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         tc_pulse,
  output logic         busy
);

  localparam logic [N-1:0] C_MAX         = N'(MAX_VAL);
  localparam logic [1:0]   C_MODE_WRAP   = 2'b00;
  localparam logic [1:0]   C_MODE_SAT    = 2'b01;
  localparam logic [1:0]   C_MODE_ONESHOT = 2'b10;
  localparam logic [1:0]   C_MODE_RELOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_nxt;
  logic [N-1:0] r_reload;
  logic [N-1:0] w_reload_nxt;
  logic         r_tc;
  logic         w_tc_nxt;
  logic [N-1:0] w_d_clamp;
  logic [N-1:0] w_term;
  logic         w_at_term;
  logic         w_step_ok;

  assign w_d_clamp = (d > C_MAX) ? C_MAX : d;
  assign w_term    = up ? C_MAX : '0;
  assign w_at_term = (r_q == w_term);
  // One-shot only counts while armed; every other mode counts whenever enabled.
  assign w_step_ok = en && ((mode != C_MODE_ONESHOT) || (r_state == ST_RUN));

  always_comb begin
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    w_state_nxt  = (mode == C_MODE_ONESHOT) ? r_state : ST_IDLE;

    if (syn_clr) begin
      w_q_nxt     = '0;
      w_state_nxt = ST_IDLE;
    end else if (load) begin
      w_q_nxt      = w_d_clamp;
      w_reload_nxt = w_d_clamp;
      w_state_nxt  = (mode == C_MODE_ONESHOT) ? ST_RUN : ST_IDLE;
    end else if (w_step_ok) begin
      if (!w_at_term) begin
        w_q_nxt = up ? (r_q + 1'b1) : (r_q - 1'b1);
      end else begin
        w_tc_nxt = 1'b1;
        case (mode)
          C_MODE_WRAP:    w_q_nxt = up ? '0 : C_MAX;
          C_MODE_SAT:     w_q_nxt = r_q;
          C_MODE_ONESHOT: w_state_nxt = ST_DONE;
          C_MODE_RELOAD:  w_q_nxt = r_reload;
          default:        w_q_nxt = r_q;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_state  <= w_state_nxt;
    end
  end

  assign q        = r_q;
  assign max_tick = (r_q == C_MAX);
  assign min_tick = (r_q == '0);
  assign tc_pulse = r_tc;
  assign busy     = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_ctl.sv
// ============================================================================
// Module   : tb_mod_counter_ctl
// Brief    : Directed and randomised checks of mod_counter_ctl (N=8, MAX_VAL=9)
//            against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter_ctl;

  localparam int C_N    = 8;
  localparam int C_MAXV = 9;

  logic           sysclk;
  logic           reset_n;
  logic           syn_clr;
  logic           load;
  logic           en;
  logic           up;
  logic [1:0]     mode;
  logic [C_N-1:0] d;
  logic [C_N-1:0] q;
  logic           max_tick;
  logic           min_tick;
  logic           tc_pulse;
  logic           busy;

  int n_cmp;
  int n_mis;

  // Reference state: count value, reload value, pulse, and whether a one-shot is armed
  int m_q;
  int m_rel;
  bit m_tc;
  bit m_armed;

  mod_counter_ctl #(.N(C_N), .MAX_VAL(C_MAXV)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .syn_clr  (syn_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .d        (d),
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .tc_pulse (tc_pulse),
    .busy     (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set(input bit c, input bit l, input bit e, input bit u,
                     input logic [1:0] m, input int dv);
    syn_clr = c; load = l; en = e; up = u; mode = m; d = C_N'(dv);
  endtask

  task automatic model_step();
    int term;
    int clamp;
    m_tc = 1'b0;
    if (syn_clr) begin
      m_q = 0;
      m_armed = 1'b0;
    end else if (load) begin
      clamp   = (int'(d) > C_MAXV) ? C_MAXV : int'(d);
      m_q     = clamp;
      m_rel   = clamp;
      m_armed = (mode == 2'b10);
    end else begin
      if (mode != 2'b10) m_armed = 1'b0;
      if (en && (mode != 2'b10 || m_armed)) begin
        term = up ? C_MAXV : 0;
        if (m_q != term) m_q = up ? m_q + 1 : m_q - 1;
        else begin
          m_tc = 1'b1;
          case (mode)
            2'b00:   m_q = up ? 0 : C_MAXV;
            2'b01:   m_q = m_q;
            2'b10:   m_armed = 1'b0;
            default: m_q = m_rel;
          endcase
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},   32'(q),        32'(m_q));
    chk({tag, ".tc"},  32'(tc_pulse), 32'(m_tc));
    chk({tag, ".busy"}, 32'(busy),    32'(m_armed));
    chk({tag, ".max"}, 32'(max_tick), 32'(m_q == C_MAXV));
    chk({tag, ".min"}, 32'(min_tick), 32'(m_q == 0));
  endtask

  // One clock: predict from current inputs, advance, sample 1 time unit after the edge
  task automatic cyc(input string tag);
    model_step();
    @(posedge sysclk);
    #1;
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_mis = 0;
    m_q = 0; m_rel = 0; m_tc = 1'b0; m_armed = 1'b0;
    reset_n = 1'b0;
    set(0, 0, 0, 0, 2'b00, 0);
    repeat (2) @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    check_model("reset");

    // Wrap up 0..9,0 then down 0->9
    set(0, 0, 1, 1, 2'b00, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc("wrap_up");
      chk("wrap_up_q", 32'(q), 32'(i));
    end
    cyc("wrap_up_term");
    chk("wrap_up_term_q", 32'(q), 0);
    chk("wrap_up_term_tc", 32'(tc_pulse), 1);
    cyc("wrap_up_after");
    chk("wrap_up_after_tc", 32'(tc_pulse), 0);
    up = 1'b0;
    cyc("wrap_dn");
    chk("wrap_dn_q0", 32'(q), 0);
    cyc("wrap_dn_term");
    chk("wrap_dn_term_q", 32'(q), 9);
    chk("wrap_dn_term_tc", 32'(tc_pulse), 1);

    // Asynchronous reset mid-count, observed before any clock edge
    set(0, 1, 0, 1, 2'b00, 5);
    cyc("pre_rst_load");
    chk("pre_rst_q", 32'(q), 5);
    reset_n = 1'b0;
    #2;
    m_q = 0; m_rel = 0; m_tc = 1'b0; m_armed = 1'b0;
    chk("async_rst_q", 32'(q), 0);
    chk("async_rst_tc", 32'(tc_pulse), 0);
    chk("async_rst_busy", 32'(busy), 0);
    #1;
    reset_n = 1'b1;

    // Saturate
    set(0, 1, 0, 1, 2'b01, 7);
    cyc("sat_load");
    set(0, 0, 1, 1, 2'b01, 0);
    cyc("sat1"); chk("sat1_q", 32'(q), 8);
    cyc("sat2"); chk("sat2_q", 32'(q), 9);
    for (int i = 0; i < 3; i++) begin
      cyc("sat_hold");
      chk("sat_hold_q", 32'(q), 9);
      chk("sat_hold_tc", 32'(tc_pulse), 1);
    end
    up = 1'b0;
    cyc("sat_dn"); chk("sat_dn_q", 32'(q), 8);

    // One-shot
    set(0, 1, 1, 0, 2'b10, 3);
    cyc("os_load");
    chk("os_load_busy", 32'(busy), 1);
    load = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      cyc("os_run");
      chk("os_run_q", 32'(q), 32'(i));
    end
    cyc("os_term");
    chk("os_term_tc", 32'(tc_pulse), 1);
    chk("os_term_busy", 32'(busy), 0);
    repeat (3) begin
      cyc("os_done");
      chk("os_done_q", 32'(q), 0);
      chk("os_done_tc", 32'(tc_pulse), 0);
    end
    set(0, 1, 1, 0, 2'b10, 1);
    cyc("os_rearm");
    chk("os_rearm_busy", 32'(busy), 1);
    load = 1'b0;
    cyc("os_rearm_run"); chk("os_rearm_q", 32'(q), 0);
    cyc("os_rearm_term");

    // Reload with clamp
    set(0, 1, 0, 1, 2'b11, 200);
    cyc("rl_clamp"); chk("rl_clamp_q", 32'(q), 9);
    set(0, 0, 1, 1, 2'b11, 0);
    cyc("rl_clamp_step");
    chk("rl_clamp_reload_q", 32'(q), 9);
    chk("rl_clamp_tc", 32'(tc_pulse), 1);
    set(0, 1, 0, 1, 2'b11, 4);
    cyc("rl_load4");
    load = 1'b0; en = 1'b1;
    for (int i = 5; i <= 9; i++) cyc("rl_up");
    cyc("rl_term");
    chk("rl_term_q", 32'(q), 4);
    chk("rl_term_tc", 32'(tc_pulse), 1);
    cyc("rl_after"); chk("rl_after_q", 32'(q), 5);

    // Priority
    set(1, 1, 1, 1, 2'b10, 6);
    cyc("prio_clr");
    chk("prio_clr_q", 32'(q), 0);
    chk("prio_clr_busy", 32'(busy), 0);
    set(0, 1, 0, 1, 2'b00, 9);
    cyc("prio_ld9");
    set(0, 1, 1, 1, 2'b00, 3);
    cyc("prio_ld_term");
    chk("prio_ld_term_q", 32'(q), 3);
    chk("prio_ld_term_tc", 32'(tc_pulse), 0);

    // Randomised run against the reference model
    mode = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      syn_clr = ($urandom_range(31) == 0);
      load    = ($urandom_range(11) == 0);
      en      = ($urandom_range(3) != 0);
      up      = 1'($urandom_range(1));
      d       = C_N'($urandom_range(255));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
